// File: rtl/instr_mem_loader.sv
// Serial-frame instruction memory loader: parses a length-prefixed byte stream, writes the
// payload into instruction memory and stalls the core until a checksum-verified load completes.
`ifndef XLEN_64b
`define XLEN_64b 2'd2
`endif

module instr_mem_loader #(
    parameter logic [1:0]  XLEN      = `XLEN_64b,
    parameter logic [63:0] LOAD_BASE = 64'd0,
    parameter int unsigned TIMEOUT   = 1000,
    localparam int unsigned AW       = 1 << (int'(XLEN) + 4)
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_start,
    input  logic [7:0]    i_rx_data,
    input  logic          i_rx_valid,
    output logic          o_rx_ready,
    output logic          o_wr_en,
    output logic [AW-1:0] o_wr_adr,
    output logic [7:0]    o_wr_data,
    output logic          o_core_hold,
    output logic          o_busy,
    output logic          o_done,
    output logic          o_err
);

    typedef enum logic [2:0] {StIdle, StHdr, StData, StChk, StDone, StErr} state_e;

    state_e      state;
    logic [20:0] byte_cnt;
    logic [20:0] last_byte;
    logic [23:0] hdr;       // header bytes 0..2; byte 3 is taken straight from i_rx_data
    logic [7:0]  csum;
    logic [31:0] idle_cnt;

    logic        accept;
    logic        timed_out;
    logic        oversize;
    logic [31:0] n_words;
    logic [63:0] load_end;

    assign o_rx_ready  = (state == StHdr) || (state == StData) || (state == StChk);
    assign o_busy      = o_rx_ready;
    assign o_done      = (state == StDone);
    assign o_err       = (state == StErr);
    assign o_core_hold = (state != StDone);

    assign accept    = i_rx_valid && o_rx_ready;
    assign timed_out = (idle_cnt >= 32'(TIMEOUT - 1));
    assign n_words   = {i_rx_data, hdr};
    assign load_end  = LOAD_BASE + {30'd0, n_words, 2'b00};
    assign oversize  = (load_end > 64'h10_0000);

    always_ff @(posedge i_clk or negedge i_rst) begin
        if (!i_rst) begin
            state     <= StIdle;
            byte_cnt  <= '0;
            last_byte <= '0;
            hdr       <= '0;
            csum      <= '0;
            idle_cnt  <= '0;
            o_wr_en   <= 1'b0;
            o_wr_adr  <= '0;
            o_wr_data <= '0;
        end else begin
            o_wr_en <= 1'b0;
            case (state)
                StIdle, StDone, StErr: begin
                    if (i_start) begin
                        state    <= StHdr;
                        byte_cnt <= '0;
                        hdr      <= '0;
                        csum     <= '0;
                        idle_cnt <= '0;
                    end
                end
                StHdr, StData, StChk: begin
                    if (accept) begin
                        idle_cnt <= '0;
                        if (state == StHdr) begin
                            hdr <= {i_rx_data, hdr[23:8]};
                            if (byte_cnt == 21'd3) begin
                                byte_cnt  <= '0;
                                last_byte <= {n_words[18:0], 2'b00} - 21'd1;
                                if (oversize) begin
                                    state <= StErr;
                                end else if (n_words == 32'd0) begin
                                    state <= StChk;
                                end else begin
                                    state <= StData;
                                end
                            end else begin
                                byte_cnt <= byte_cnt + 21'd1;
                            end
                        end else if (state == StData) begin
                            o_wr_en   <= 1'b1;
                            o_wr_adr  <= AW'(LOAD_BASE) + AW'(byte_cnt);
                            o_wr_data <= i_rx_data;
                            csum      <= csum ^ i_rx_data;
                            byte_cnt  <= byte_cnt + 21'd1;
                            if (byte_cnt == last_byte) begin
                                state <= StChk;
                            end
                        end else if (i_rx_data == csum) begin
                            state <= StDone;
                        end else begin
                            state <= StErr;
                        end
                    end else if (timed_out) begin
                        // An accepted byte in the same cycle always wins over the timeout
                        state <= StErr;
                    end else begin
                        idle_cnt <= idle_cnt + 32'd1;
                    end
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule

// File: tb/tb_instr_mem_loader.sv
// Randomized scoreboard bench for instr_mem_loader: expected writes are queued as bytes are
// issued and a negedge monitor pops and compares every write the loader emits.
module tb_instr_mem_loader;

    localparam logic [63:0] LOAD_BASE = 64'd0;
    localparam int unsigned TIMEOUT   = 8;

    logic        i_clk = 1'b0;
    logic        i_rst = 1'b0;
    logic        i_start = 1'b0;
    logic [7:0]  i_rx_data = 8'h00;
    logic        i_rx_valid = 1'b0;
    logic        o_rx_ready;
    logic        o_wr_en;
    logic [63:0] o_wr_adr;
    logic [7:0]  o_wr_data;
    logic        o_core_hold;
    logic        o_busy;
    logic        o_done;
    logic        o_err;

    int          tests = 0;
    int          fails = 0;
    int          wr_count = 0;
    logic [71:0] exp_q[$];    // {address, data} of each write the model predicts
    logic [7:0]  pay_q[$];    // payload of the frame about to be sent

    instr_mem_loader #(
        .LOAD_BASE(LOAD_BASE),
        .TIMEOUT  (TIMEOUT)
    ) dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_rx_data  (i_rx_data),
        .i_rx_valid (i_rx_valid),
        .o_rx_ready (o_rx_ready),
        .o_wr_en    (o_wr_en),
        .o_wr_adr   (o_wr_adr),
        .o_wr_data  (o_wr_data),
        .o_core_hold(o_core_hold),
        .o_busy     (o_busy),
        .o_done     (o_done),
        .o_err      (o_err)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [79:0] act, input logic [79:0] req);
        tests++;
        if (act !== req) begin
            fails++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Flags packed as {busy, done, err, core_hold}; called only between frames
    task automatic check_status(input string name, input bit d, input bit e);
        check({name, " status"}, 80'({o_busy, o_done, o_err, o_core_hold}),
              80'({1'b0, d, e, ~d}));
    endtask

    always @(negedge i_clk) begin
        if (o_wr_en) begin
            wr_count++;
            if (exp_q.size() == 0) begin
                tests++;
                fails++;
                $display("FAIL unexpected_write: adr %0h data %0h, required no write",
                         o_wr_adr, o_wr_data);
            end else begin
                check("write", 80'({o_wr_adr, o_wr_data}), 80'(exp_q.pop_front()));
            end
        end
    end

    function automatic int pick_gap(input int mode);
        if (mode == 0) return 0;
        if (mode == 1) return 1;
        return int'($urandom_range(3));
    endfunction

    task automatic start_load();
        @(negedge i_clk);
        i_start = 1'b1;
        @(negedge i_clk);
        i_start = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input int gap, input bit is_pay,
                             input logic [63:0] adr, input bit pulse_start);
        int bound;
        bound = 0;
        repeat (gap) @(negedge i_clk);
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = b;
        i_start    = pulse_start;
        while (!o_rx_ready && bound < 20) begin
            @(negedge i_clk);
            bound++;
        end
        if (!o_rx_ready) begin
            tests++;
            fails++;
            $display("FAIL rx_ready_wait: ready 0 after %0d cycles, required 1", bound);
        end else if (is_pay) begin
            exp_q.push_back({adr, b});
        end
        @(posedge i_clk);
        #1;
        i_rx_valid = 1'b0;
        i_start    = 1'b0;
    endtask

    // Reference: frame is rejected if it overruns 1 MiB, else succeeds iff chk is the payload XOR
    task automatic run_frame(input string name, input logic [31:0] n, input logic [7:0] chk,
                             input int gap_mode, input int start_at);
        logic [7:0]  x;
        logic [63:0] span;
        bit          too_big;
        x       = 8'h00;
        span    = LOAD_BASE + 64'(n) * 64'd4;
        too_big = (span > 64'h10_0000);
        wr_count = 0;
        start_load();
        for (int i = 0; i < 4; i++) begin
            send_byte(n[8*i +: 8], pick_gap(gap_mode), 1'b0, 64'd0, 1'b0);
        end
        if (!too_big) begin
            for (int k = 0; k < pay_q.size(); k++) begin
                x ^= pay_q[k];
                send_byte(pay_q[k], pick_gap(gap_mode), 1'b1, LOAD_BASE + 64'(k), k == start_at);
            end
            send_byte(chk, pick_gap(gap_mode), 1'b0, 64'd0, 1'b0);
        end
        @(negedge i_clk);
        check({name, " writes"}, 80'(wr_count), too_big ? 80'd0 : 80'(pay_q.size()));
        check({name, " pending"}, 80'(exp_q.size()), 80'd0);
        check_status(name, !too_big && (chk == x), too_big || (chk != x));
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $fatal(1);
    end

    initial begin
        logic [7:0] x;
        int         n;

        #12;
        check("reset outputs",
              80'({o_rx_ready, o_wr_en, o_wr_adr, o_wr_data, o_core_hold, o_busy, o_done, o_err}),
              80'({1'b0, 1'b0, 64'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (3) @(negedge i_clk);
        check_status("idle", 1'b0, 1'b0);

        // Two-word program; payload XOR is 0x90, so 0x80 is rejected and 0x90 accepted
        pay_q = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
        run_frame("prog chk80", 32'd2, 8'h80, 0, -1);
        run_frame("prog chk90", 32'd2, 8'h90, 0, -1);

        pay_q = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_frame("aabbccdd chk00", 32'd1, 8'h00, 0, -1);
        run_frame("aabbccdd chk01", 32'd1, 8'h01, 0, -1);

        pay_q.delete();
        run_frame("empty chk00", 32'd0, 8'h00, 0, -1);
        run_frame("empty chk05", 32'd0, 8'h05, 0, -1);
        run_frame("oversize", 32'h0004_0001, 8'h00, 0, -1);

        // Idle timeout after two payload bytes
        wr_count = 0;
        start_load();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h02 : 8'h00, 0, 1'b0, 64'd0, 1'b0);
        send_byte(8'h11, 0, 1'b1, LOAD_BASE, 1'b0);
        send_byte(8'h22, 0, 1'b1, LOAD_BASE + 64'd1, 1'b0);
        repeat (TIMEOUT - 1) @(posedge i_clk);
        @(negedge i_clk);
        check("timeout early", 80'(o_err), 80'd0);
        @(posedge i_clk);
        @(negedge i_clk);
        check("timeout err", 80'(o_err), 80'd1);
        repeat (4) @(negedge i_clk);
        check("timeout writes", 80'(wr_count), 80'd2);
        check("timeout pending", 80'(exp_q.size()), 80'd0);
        start_load();
        check("restart", 80'({o_busy, o_err}), 80'({1'b1, 1'b0}));
        // The frame's own start pulse lands in HDR and must be ignored
        run_frame("restart empty", 32'd0, 8'h00, 0, -1);

        // Randomized frames: back-to-back, alternating valid, random gaps, mid-frame i_start
        for (int f = 0; f < 9; f++) begin
            n = int'($urandom_range(1, 5));
            pay_q.delete();
            x = 8'h00;
            for (int k = 0; k < 4 * n; k++) begin
                pay_q.push_back(8'($urandom));
                x ^= pay_q[k];
            end
            if ($urandom_range(3) == 0) x = x ^ 8'($urandom_range(1, 255));
            run_frame($sformatf("rand%0d", f), 32'(n), x, f % 3,
                      (f % 2 == 1) ? int'($urandom_range(4 * n - 1)) : -1);
        end

        // Asynchronous reset in the middle of DATA, with a byte offered but not yet taken
        wr_count = 0;
        start_load();
        for (int i = 0; i < 4; i++) send_byte((i == 0) ? 8'h01 : 8'h00, 0, 1'b0, 64'd0, 1'b0);
        send_byte(8'h31, 0, 1'b1, LOAD_BASE, 1'b0);
        send_byte(8'h32, 0, 1'b1, LOAD_BASE + 64'd1, 1'b0);
        @(negedge i_clk);
        i_rx_valid = 1'b1;
        i_rx_data  = 8'h5A;
        #2;
        i_rst = 1'b0;
        #1;
        check("async reset",
              80'({o_rx_ready, o_wr_en, o_wr_adr, o_wr_data, o_core_hold, o_busy, o_done, o_err}),
              80'({1'b0, 1'b0, 64'd0, 8'd0, 1'b1, 1'b0, 1'b0, 1'b0}));
        @(posedge i_clk);
        #1;
        check("reset no write", 80'(o_wr_en), 80'd0);
        i_rx_valid = 1'b0;
        @(negedge i_clk);
        i_rst = 1'b1;
        repeat (2) @(negedge i_clk);
        check("reset writes", 80'(wr_count), 80'd2);
        check("reset pending", 80'(exp_q.size()), 80'd0);
        check_status("after reset", 1'b0, 1'b0);

        pay_q = '{8'h01, 8'h02, 8'h03, 8'h04};
        run_frame("post reset", 32'd1, 8'h04, 2, -1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
